freelist_mp: RTL and testbench
==============================

// Module: freelist_mp
// PURPOSE
// - Multi-port free-tag pool: hands out up to DEQ_PORTS tags and accepts up to ENQ_PORTS freed tags per cycle.
// - Circular RAM of tags with head/tail pointers and an explicit occupancy counter.
// - Supports ENTRY_COUNT values that are not powers of two.
// - Serves superscalar allocators (MSHR/LSQ/rename-style IDs) in the L1D and core; flush restores the full identity pool.
// PARAMETERS
// - ENTRY_COUNT  16  number of tags; tags are 0..ENTRY_COUNT-1; legal range >=2, need not be a power of two
// - ENQ_PORTS    2   number of release (enqueue) ports, 1..ENTRY_COUNT
// - DEQ_PORTS    2   number of allocate (dequeue) ports, 1..ENTRY_COUNT
// - TAG_W        localparam, $clog2(ENTRY_COUNT)
// - CNT_W        localparam, $clog2(ENTRY_COUNT+1)
// PORTS
// - clk        in   1                  clock, rising edge
// - rst        in   1                  asynchronous reset, active-low
// - enq_vld_i  in   ENQ_PORTS          per-port release valid; any bit pattern allowed
// - enq_tag_i  in   ENQ_PORTS*TAG_W    released tags
// - deq_vld_i  in   DEQ_PORTS          per-port allocate request
// - deq_rdy_o  out  DEQ_PORTS          port i can allocate this cycle
// - deq_tag_o  out  DEQ_PORTS*TAG_W    tag offered on port i
// - free_cnt_o out  CNT_W              tags currently free (registered)
// - ovf_o      out  1                  pulse: release would exceed capacity
// - flush_i    in   1                  synchronous restore to the full identity pool
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - ram[i]=i; head=0; tail=0; count=ENTRY_COUNT.
//   - deq_rdy_o=all ones, limited to DEQ_PORTS<=ENTRY_COUNT; deq_tag_o[i]=i; free_cnt_o=ENTRY_COUNT; ovf_o=0.
// - Pointer arithmetic: all pointers and offsets are computed modulo ENTRY_COUNT by explicit compare/subtract, never by bit truncation.
// - Allocate:
//   - deq_tag_o[i]=ram[(head+i)%N]; deq_rdy_o[i]=(count>i). Both are combinational from registered state only.
//   - deq_vld_i must be thermometer-coded from port 0; a non-contiguous pattern is a checker error.
//   - deq_cnt = number of ports with deq_vld_i & deq_rdy_o; head advances by deq_cnt at the clock edge.
//   - Zero-latency offer: the tag is valid in the request cycle and consumed at the edge.
// - Release:
//   - Valid enq ports are compacted in ascending port order into ram[(tail+k)%N], k=0..enq_cnt-1.
//   - tail advances by the number of tags written.
// - Counter: count_n = count + enq_written - deq_cnt. Sum width is CNT_W+1 to avoid overflow.
// - Simultaneous alloc and release are both applied in the same cycle.
// - No bypass: when count==0, a tag released in cycle t is allocatable from t+1 onward.
// - Capacity:
//   - Limit: count - deq_cnt + enq_cnt <= N.
//   - Excess enq ports (highest index first) are dropped and ovf_o=1 for that cycle.
//   - State never exceeds N.
// - Flush:
//   - Priority over enq and deq in the same cycle.
//   - Next state equals the reset state; ovf_o=0; in-flight deq grants that cycle are void.
// - Reset mid-operation: all state returns to the reset values immediately; no partial writes survive.
// - Wrap-around: head/tail at N-1 plus 1 become 0, including multi-step advances (e.g. N=6, tail=5, +2 -> 1).
// CONFIGURATION
// - Macro FREELIST_MP_DUPCHK_EN:
//   - Defined: adds an ENTRY_COUNT-bit free-vector, reset/flush all ones.
//     - Bit is cleared on allocation and set on release.
//     - Releasing a tag whose bit is already 1, or the same tag on two ports in one cycle, sets sticky output dup_err_o (1 bit, cleared only by reset/flush).
//     - The offending write is dropped.
//   - Undefined: no free-vector and no dup_err_o port; duplicate releases are stored unchecked.
// TESTING
// - N=16, D=2, E=2. Reset, then deq_vld=2'b11 for 3 cycles -> tags (0,1),(2,3),(4,5); free_cnt 16->14->12->10.
// - N=6 wrap. Drain all 6 tags, release tags 5,3 on ports 0,1, then 4 -> ram[0..2]=5,3,4; tail=3; next alloc returns 5,3.
// - Empty. count=0, release 7 with deq_vld=2'b01 in the same cycle -> deq_rdy_o=0, no grant; next cycle deq_tag_o[0]=7, deq_rdy_o=2'b01.
// - Simultaneous. count=1, deq_vld=2'b11 + release 9 -> only port 0 granted; count stays 1; next offer is 9.
// - Overflow/flush. count=15, release 2 tags -> ovf_o=1, port 1 dropped, count=16. Then flush with deq_vld=2'b11 -> count=16, head=tail=0, deq_tag_o=0,1.
// - FREELIST_MP_DUPCHK_EN. Release tag 3 while it is still free -> dup_err_o=1, count unchanged; flush -> dup_err_o=0.

Source files
------------

// File: rtl/freelist_mp.sv
// Multi-port free-tag pool: circular tag RAM, head/tail pointers, occupancy count.
// Define FREELIST_MP_DUPCHK_EN to add the free-vector duplicate-release checker.
module freelist_mp #(
    parameter int  ENTRY_COUNT = 16,
    parameter int  ENQ_PORTS   = 2,
    parameter int  DEQ_PORTS   = 2,
    localparam int TAG_W       = $clog2(ENTRY_COUNT),
    localparam int CNT_W       = $clog2(ENTRY_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ENQ_PORTS-1:0]       enq_vld_i,
    input  logic [ENQ_PORTS*TAG_W-1:0] enq_tag_i,
    input  logic [DEQ_PORTS-1:0]       deq_vld_i,
    output logic [DEQ_PORTS-1:0]       deq_rdy_o,
    output logic [DEQ_PORTS*TAG_W-1:0] deq_tag_o,
    output logic [CNT_W-1:0]           free_cnt_o,
    output logic                       ovf_o,
    input  logic                       flush_i
`ifdef FREELIST_MP_DUPCHK_EN
    ,
    output logic                       dup_err_o
`endif
);

    localparam int            PW = CNT_W + 1;
    localparam logic [PW-1:0] NP = PW'(ENTRY_COUNT);

    logic [TAG_W-1:0]     ram_q [ENTRY_COUNT];
    logic [TAG_W-1:0]     ram_d [ENTRY_COUNT];
    logic [TAG_W-1:0]     head_q, head_d;
    logic [TAG_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PW-1:0]        deq_cnt, wr_cnt, room;
    logic [ENQ_PORTS-1:0] enq_ok, wr_mask;
    logic [DEQ_PORTS-1:0] deq_gnt, vld_p1;
    logic                 ovf;

    // Modulo-N add by compare/subtract so non-power-of-two sizes wrap correctly
    function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] p,
                                                  input logic [PW-1:0]    off);
        logic [PW-1:0] s;
        s = PW'(p) + off;
        if (s >= NP) s = s - NP;
        return TAG_W'(s);
    endfunction

    always_comb begin
        deq_rdy_o = '0;
        deq_tag_o = '0;
        deq_gnt   = '0;
        deq_cnt   = '0;
        for (int i = 0; i < DEQ_PORTS; i++) begin
            deq_rdy_o[i] = count_q > CNT_W'(i);
            deq_tag_o[i*TAG_W +: TAG_W] = ram_q[wrap_add(head_q, PW'(i))];
            deq_gnt[i] = deq_vld_i[i] & deq_rdy_o[i];
            if (deq_gnt[i]) deq_cnt = deq_cnt + PW'(1);
        end
    end

`ifdef FREELIST_MP_DUPCHK_EN
    logic [ENTRY_COUNT-1:0] fv_q, fv_d;
    logic                   dup_q, dup_d, dup_hit;

    always_comb begin
        enq_ok  = '0;
        dup_hit = 1'b0;
        for (int j = 0; j < ENQ_PORTS; j++) begin
            if (enq_vld_i[j]) begin
                enq_ok[j] = 1'b1;
                if (PW'(enq_tag_i[j*TAG_W +: TAG_W]) >= NP)
                    enq_ok[j] = 1'b0;
                else if (fv_q[enq_tag_i[j*TAG_W +: TAG_W]])
                    enq_ok[j] = 1'b0;
                for (int k = 0; k < j; k++)
                    if (enq_vld_i[k] &&
                        enq_tag_i[k*TAG_W +: TAG_W] == enq_tag_i[j*TAG_W +: TAG_W])
                        enq_ok[j] = 1'b0;
                if (!enq_ok[j]) dup_hit = 1'b1;
            end
        end
    end

    always_comb begin
        fv_d  = fv_q;
        dup_d = dup_q | dup_hit;
        for (int i = 0; i < DEQ_PORTS; i++)
            if (deq_gnt[i]) fv_d[deq_tag_o[i*TAG_W +: TAG_W]] = 1'b0;
        for (int j = 0; j < ENQ_PORTS; j++)
            if (wr_mask[j]) fv_d[enq_tag_i[j*TAG_W +: TAG_W]] = 1'b1;
        if (flush_i) begin
            fv_d  = '1;
            dup_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fv_q  <= '1;
            dup_q <= 1'b0;
        end else begin
            fv_q  <= fv_d;
            dup_q <= dup_d;
        end
    end

    assign dup_err_o = dup_q;
`else
    assign enq_ok = enq_vld_i;
`endif

    // Compact accepted releases from the tail; excess high ports are dropped
    always_comb begin
        ram_d   = ram_q;
        wr_cnt  = '0;
        wr_mask = '0;
        ovf     = 1'b0;
        room    = NP - PW'(count_q) + deq_cnt;
        for (int j = 0; j < ENQ_PORTS; j++) begin
            if (enq_ok[j]) begin
                if (wr_cnt < room) begin
                    ram_d[wrap_add(tail_q, wr_cnt)] = enq_tag_i[j*TAG_W +: TAG_W];
                    wr_mask[j] = 1'b1;
                    wr_cnt     = wr_cnt + PW'(1);
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        head_d  = wrap_add(head_q, deq_cnt);
        tail_d  = wrap_add(tail_q, wr_cnt);
        count_d = CNT_W'(PW'(count_q) + wr_cnt - deq_cnt);
        if (flush_i) begin
            for (int i = 0; i < ENTRY_COUNT; i++) ram_d[i] = TAG_W'(i);
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(ENTRY_COUNT);
            ovf     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) ram_q[i] <= TAG_W'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(ENTRY_COUNT);
        end else begin
            ram_q   <= ram_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign free_cnt_o = count_q;
    assign ovf_o      = ovf;

    assign vld_p1 = deq_vld_i + DEQ_PORTS'(1);

    deq_thermo_a: assert property (@(posedge clk) disable iff (!rst)
        (deq_vld_i & vld_p1) == '0);

endmodule

// File: tb/tb_freelist_mp.sv
// Scoreboard bench for freelist_mp: a 16-entry and a 6-entry instance
// checked cycle by cycle against a queue model of the free pool.
module tb_freelist_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] a_ev, a_dv, a_rdy;
    logic [7:0] a_et, a_dt;
    logic [4:0] a_cnt;
    logic       a_ovf, a_fl;
    logic [1:0] b_ev, b_dv, b_rdy;
    logic [5:0] b_et, b_dt;
    logic [2:0] b_cnt;
    logic       b_ovf, b_fl;
`ifdef FREELIST_MP_DUPCHK_EN
    logic       a_dup, b_dup;
`endif

    freelist_mp #(.ENTRY_COUNT(16), .ENQ_PORTS(2), .DEQ_PORTS(2)) u_a (
        .clk(clk), .rst(rst),
        .enq_vld_i(a_ev), .enq_tag_i(a_et),
        .deq_vld_i(a_dv), .deq_rdy_o(a_rdy), .deq_tag_o(a_dt),
        .free_cnt_o(a_cnt), .ovf_o(a_ovf), .flush_i(a_fl)
`ifdef FREELIST_MP_DUPCHK_EN
        , .dup_err_o(a_dup)
`endif
    );

    freelist_mp #(.ENTRY_COUNT(6), .ENQ_PORTS(2), .DEQ_PORTS(2)) u_b (
        .clk(clk), .rst(rst),
        .enq_vld_i(b_ev), .enq_tag_i(b_et),
        .deq_vld_i(b_dv), .deq_rdy_o(b_rdy), .deq_tag_o(b_dt),
        .free_cnt_o(b_cnt), .ovf_o(b_ovf), .flush_i(b_fl)
`ifdef FREELIST_MP_DUPCHK_EN
        , .dup_err_o(b_dup)
`endif
    );

    int fl0[$], fl1[$], held0[$], held1[$];
    int exp_q[$];
    bit dup0, dup1;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic model_reset(input int sel);
        int n;
        n = sel ? 6 : 16;
        if (sel == 0) begin
            fl0.delete(); held0.delete(); dup0 = 1'b0;
            for (int k = 0; k < n; k++) fl0.push_back(k);
        end else begin
            fl1.delete(); held1.delete(); dup1 = 1'b0;
            for (int k = 0; k < n; k++) fl1.push_back(k);
        end
    endtask

    task automatic drive(input int sel, input logic [1:0] dv, input logic [1:0] ev,
                         input int t0, input int t1, input logic fl);
        a_dv = '0; a_ev = '0; a_et = '0; a_fl = 1'b0;
        b_dv = '0; b_ev = '0; b_et = '0; b_fl = 1'b0;
        if (sel == 0) begin
            a_dv = dv; a_ev = ev; a_fl = fl;
            a_et = {4'(t1), 4'(t0)};
        end else begin
            b_dv = dv; b_ev = ev; b_fl = fl;
            b_et = {3'(t1), 3'(t0)};
        end
    endtask

    // One cycle: drive at posedge+1, check at posedge+2, advance model past the edge
    task automatic step(input int sel, input logic [1:0] dv, input logic [1:0] ev,
                        input int t0, input int t1, input logic fl);
        int q[$], h[$], wl[$];
        int n, g, room, got_rdy, got_cnt, got_ovf, exp_ovf, got_dup;
        int tg[2], tv[2];
        bit ok[2];
        bit dm;
        string p;
        p = sel ? "B" : "A";
        n = sel ? 6 : 16;
        if (sel == 0) begin q = fl0; h = held0; dm = dup0; end
        else          begin q = fl1; h = held1; dm = dup1; end
        tv[0] = t0;
        tv[1] = t1;
        drive(sel, dv, ev, t0, t1, fl);
        for (int i = 0; i < 2; i++)
            if (i < q.size()) exp_q.push_back(q[i]);
        #1;
        got_dup = 0;
        if (sel == 0) begin
            got_rdy = a_rdy; got_cnt = a_cnt; got_ovf = a_ovf;
            tg[0] = a_dt[3:0]; tg[1] = a_dt[7:4];
`ifdef FREELIST_MP_DUPCHK_EN
            got_dup = a_dup;
`endif
        end else begin
            got_rdy = b_rdy; got_cnt = b_cnt; got_ovf = b_ovf;
            tg[0] = b_dt[2:0]; tg[1] = b_dt[5:3];
`ifdef FREELIST_MP_DUPCHK_EN
            got_dup = b_dup;
`endif
        end
        check({p, ".cnt"}, got_cnt, q.size());
        check({p, ".rdy"}, got_rdy, q.size() >= 2 ? 3 : q.size());
        for (int i = 0; i < 2; i++)
            if (i < q.size())
                check($sformatf("%s.tag%0d", p, i), tg[i], exp_q.pop_front());
`ifdef FREELIST_MP_DUPCHK_EN
        check({p, ".dup"}, got_dup, int'(dm));
`endif
        g = 0;
        for (int i = 0; i < 2; i++)
            if (dv[i] && i < q.size()) g++;
        ok[0] = ev[0];
        ok[1] = ev[1];
`ifdef FREELIST_MP_DUPCHK_EN
        for (int j = 0; j < 2; j++) begin
            if (ev[j]) begin
                foreach (q[k]) if (q[k] == tv[j]) ok[j] = 1'b0;
                if (j == 1 && ev[0] && t0 == t1) ok[j] = 1'b0;
                if (!ok[j]) dm = 1'b1;
            end
        end
`endif
        room    = n - q.size() + g;
        exp_ovf = 0;
        for (int j = 0; j < 2; j++)
            if (ok[j]) begin
                if (wl.size() < room) wl.push_back(tv[j]);
                else exp_ovf = 1;
            end
        if (fl) exp_ovf = 0;
        check({p, ".ovf"}, got_ovf, exp_ovf);
        if (fl) begin
            q.delete(); h.delete(); dm = 1'b0;
            for (int k = 0; k < n; k++) q.push_back(k);
        end else begin
            for (int i = 0; i < g; i++) h.push_back(q.pop_front());
            foreach (wl[k]) q.push_back(wl[k]);
        end
        if (sel == 0) begin fl0 = q; held0 = h; dup0 = dm; end
        else          begin fl1 = q; held1 = h; dup1 = dm; end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int sel, input int cycles);
        int h[$];
        int idx, t0, t1, r;
        logic [1:0] dv, ev;
        logic fl;
        for (int c = 0; c < cycles; c++) begin
            h = sel ? held1 : held0;
            ev = '0; t0 = 0; t1 = 0;
            r = $urandom_range(0, 2);
            dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            for (int j = 0; j < 2; j++) begin
                if (h.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, h.size() - 1);
                    if (j == 0) t0 = h[idx]; else t1 = h[idx];
                    h.delete(idx);
                    ev[j] = 1'b1;
                end
            end
            fl = ($urandom_range(0, 49) == 0);
            if (sel == 0) held0 = h; else held1 = h;
            step(sel, dv, ev, t0, t1, fl);
        end
    endtask

    int rel[14];

    initial begin
        rst = 1'b0;
        drive(0, 2'b00, 2'b00, 0, 0, 1'b0);
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 16-entry: reset state then three double allocations
        step(0, 2'b00, 2'b00, 0, 0, 1'b0);
        repeat (3) step(0, 2'b11, 2'b00, 0, 0, 1'b0);
        check("A.cnt_after3", a_cnt, 10);
        repeat (4) step(0, 2'b11, 2'b00, 0, 0, 1'b0);
        step(0, 2'b01, 2'b00, 0, 0, 1'b0);

        // count=1: both ports request while 9 is released
        step(0, 2'b11, 2'b01, 9, 0, 1'b0);
        check("A.sim_cnt", a_cnt, 1);
        check("A.sim_next", a_dt[3:0], 9);

        // empty: release 7 while requesting, no bypass
        step(0, 2'b01, 2'b00, 0, 0, 1'b0);
        step(0, 2'b01, 2'b01, 7, 0, 1'b0);
        check("A.empty_rdy", a_rdy, 1);
        check("A.empty_tag", a_dt[3:0], 7);

        // refill to 15, then overflow, then flush with requests and releases
        rel = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
        for (int k = 0; k < 7; k++)
            step(0, 2'b00, 2'b11, rel[2*k], rel[2*k+1], 1'b0);
        step(0, 2'b00, 2'b11, 15, 7, 1'b0);
        check("A.ovf_cnt", a_cnt, 16);
        step(0, 2'b11, 2'b11, 2, 4, 1'b1);
        check("A.flush_cnt", a_cnt, 16);
        check("A.flush_tags", a_dt, 8'h10);

        // 6-entry wrap
        step(1, 2'b00, 2'b00, 0, 0, 1'b0);
        repeat (3) step(1, 2'b11, 2'b00, 0, 0, 1'b0);
        step(1, 2'b00, 2'b11, 5, 3, 1'b0);
        step(1, 2'b00, 2'b01, 4, 0, 1'b0);
        check("B.wrap_t0", b_dt[2:0], 5);
        check("B.wrap_t1", b_dt[5:3], 3);
        step(1, 2'b11, 2'b00, 0, 0, 1'b0);
        step(1, 2'b00, 2'b00, 0, 0, 1'b1);

        rand_phase(0, 300);
        rand_phase(1, 300);

`ifdef FREELIST_MP_DUPCHK_EN
        step(0, 2'b00, 2'b00, 0, 0, 1'b1);
        step(0, 2'b11, 2'b00, 0, 0, 1'b0);
        step(0, 2'b00, 2'b01, 3, 0, 1'b0);
        check("A.dup_set", a_dup, 1);
        check("A.dup_cnt", a_cnt, 14);
        step(0, 2'b00, 2'b11, 0, 0, 1'b0);
        check("A.dup_pair_cnt", a_cnt, 15);
        step(0, 2'b00, 2'b00, 0, 0, 1'b1);
        check("A.dup_clr", a_dup, 0);
`endif

        // asynchronous reset in the middle of traffic
        step(0, 2'b11, 2'b00, 0, 0, 1'b0);
        step(1, 2'b11, 2'b00, 0, 0, 1'b0);
        drive(0, 2'b00, 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        #1;
        check("A.rst_cnt", a_cnt, 16);
        check("A.rst_rdy", a_rdy, 3);
        check("A.rst_tags", a_dt, 8'h10);
        check("B.rst_cnt", b_cnt, 6);
        check("B.rst_tags", b_dt, 6'o10);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 2'b11, 2'b00, 0, 0, 1'b0);
        step(1, 2'b11, 2'b00, 0, 0, 1'b0);
        step(0, 2'b00, 2'b00, 0, 0, 1'b0);
        step(1, 2'b00, 2'b00, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
